// File: rtl/decode_pkg.sv
// Shared definitions for the 16-bit MIPS ID stage: opcodes, ALUOp codes,
// instruction field positions and the decoded control bundle.
package decode_pkg;

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_LW   = 4'b0100;
    localparam logic [3:0] OP_SW   = 4'b0101;
    localparam logic [3:0] OP_BEQ  = 4'b0110;
    localparam logic [3:0] OP_ADDI = 4'b0111;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RS_MSB  = 11;
    localparam int RS_LSB  = 9;
    localparam int RT_MSB  = 8;
    localparam int RT_LSB  = 6;
    localparam int RD_MSB  = 5;
    localparam int RD_LSB  = 3;
    localparam int FN_MSB  = 2;
    localparam int FN_LSB  = 0;
    localparam int IMM_MSB = 5;
    localparam int IMM_LSB = 0;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/register_file.sv
// 8x16 register file: two combinational read ports with write-through bypass,
// one write port, r0 hardwired to zero, asynchronous active-low clear.
module register_file #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    localparam int NREGS = 1 << REG_AW;

    logic [NREGS-1:0][DATA_W-1:0] regs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            regs <= '0;
        else if (we && waddr != '0)
            regs[waddr] <= wdata;
    end

    // WB data is forwarded so ID sees a value written in the same cycle.
    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
        if (we && waddr == raddr1) rdata1 = wdata;
        if (we && waddr == raddr2) rdata2 = wdata;
        if (raddr1 == '0) rdata1 = '0;
        if (raddr2 == '0) rdata2 = '0;
    end

endmodule

// File: rtl/decode_stage.sv
// ID stage: decodes the IF/ID instruction, reads operands, detects load-use
// hazards and registers everything into the ID/EX pipeline register.
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_Instruction,
    input  logic [DATA_W-1:0] in_PC_plus_two,
    input  logic              in_valid,
    input  logic              in_flush,
    input  logic              in_WB_RegWrite,
    input  logic [REG_AW-1:0] in_WB_WriteReg,
    input  logic [DATA_W-1:0] in_WB_WriteData,
    output logic [DATA_W-1:0] O_Read_Data_1,
    output logic [DATA_W-1:0] O_Read_Data_2,
    output logic [DATA_W-1:0] O_Immediate,
    output logic              O_ALUSrc,
    output logic [1:0]        O_ALUOp,
    output logic [DATA_W-1:0] O_PC_plus_two,
    output logic              O_RegWrite,
    output logic              O_MemRead,
    output logic              O_MemWrite,
    output logic              O_MemToReg,
    output logic              O_Branch,
    output logic [REG_AW-1:0] O_WriteReg,
    output logic [REG_AW-1:0] O_Rs,
    output logic [REG_AW-1:0] O_Rt,
    output logic              O_Stall,
    output logic              O_Illegal
);

    logic [3:0]        op;
    logic [REG_AW-1:0] rs, rt, rd;
    logic [2:0]        funct;
    logic [5:0]        imm6;

    assign op    = in_Instruction[OP_MSB:OP_LSB];
    assign rs    = in_Instruction[RS_MSB:RS_LSB];
    assign rt    = in_Instruction[RT_MSB:RT_LSB];
    assign rd    = in_Instruction[RD_MSB:RD_LSB];
    assign funct = in_Instruction[FN_MSB:FN_LSB];
    assign imm6  = in_Instruction[IMM_MSB:IMM_LSB];

    logic [DATA_W-1:0] rdata1, rdata2;

    register_file #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rf (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .we     (in_WB_RegWrite),
        .waddr  (in_WB_WriteReg),
        .wdata  (in_WB_WriteData)
    );

    ctrl_t             ctrl;
    logic [REG_AW-1:0] wreg_d;
    logic              uses_rt;
    logic [DATA_W-1:0] imm_d;

    always_comb begin
        ctrl    = '0;
        wreg_d  = '0;
        uses_rt = 1'b0;
        case (op)
            OP_R: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_RTYPE;
                wreg_d         = rd;
                uses_rt        = 1'b1;
            end
            OP_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.alu_op     = ALUOP_ADD;
                wreg_d          = rt;
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALUOP_ADD;
                uses_rt        = 1'b1;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALUOP_SUB;
                uses_rt     = 1'b1;
            end
            OP_ADDI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALUOP_ADD;
                wreg_d         = rt;
            end
            OP_NOP:  ;
            default: ctrl.illegal = 1'b1;
        endcase
    end

    // R-type carries funct in the immediate; bit 3 stays 0 for the EX function code.
    assign imm_d = (op == OP_R) ? {{(DATA_W-3){1'b0}}, funct}
                                : {{(DATA_W-6){imm6[5]}}, imm6};

    logic load_use, bubble;

    assign load_use = in_valid && O_MemRead && (O_WriteReg != '0) &&
                      ((O_WriteReg == rs) || (uses_rt && (O_WriteReg == rt)));
    assign O_Stall  = load_use && !in_flush;
    assign bubble   = in_flush || !in_valid || load_use;

    ctrl_t idex_ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || bubble) begin
            idex_ctrl     <= '0;
            O_Read_Data_1 <= '0;
            O_Read_Data_2 <= '0;
            O_Immediate   <= '0;
            O_PC_plus_two <= '0;
            O_WriteReg    <= '0;
            O_Rs          <= '0;
            O_Rt          <= '0;
        end else begin
            idex_ctrl     <= ctrl;
            O_Read_Data_1 <= rdata1;
            O_Read_Data_2 <= rdata2;
            O_Immediate   <= imm_d;
            O_PC_plus_two <= in_PC_plus_two;
            O_WriteReg    <= wreg_d;
            O_Rs          <= rs;
            O_Rt          <= rt;
        end
    end

    assign O_RegWrite = idex_ctrl.reg_write;
    assign O_MemRead  = idex_ctrl.mem_read;
    assign O_MemWrite = idex_ctrl.mem_write;
    assign O_MemToReg = idex_ctrl.mem_to_reg;
    assign O_Branch   = idex_ctrl.branch;
    assign O_ALUSrc   = idex_ctrl.alu_src;
    assign O_ALUOp    = idex_ctrl.alu_op;
    assign O_Illegal  = idex_ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: each driven slot pushes its expected
// ID/EX contents, popped and compared one cycle later.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr, pc;
    logic        valid, flush, wb_we;
    logic [2:0]  wb_wa;
    logic [15:0] wb_wd;
    logic [15:0] rd1, rd2, imm, pco;
    logic        alusrc, regw, memr, memw, m2r, br, stall, ill;
    logic [1:0]  aluop;
    logic [2:0]  wreg, ors, ort;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_Instruction(instr), .in_PC_plus_two(pc),
        .in_valid(valid), .in_flush(flush),
        .in_WB_RegWrite(wb_we), .in_WB_WriteReg(wb_wa), .in_WB_WriteData(wb_wd),
        .O_Read_Data_1(rd1), .O_Read_Data_2(rd2), .O_Immediate(imm),
        .O_ALUSrc(alusrc), .O_ALUOp(aluop), .O_PC_plus_two(pco),
        .O_RegWrite(regw), .O_MemRead(memr), .O_MemWrite(memw),
        .O_MemToReg(m2r), .O_Branch(br), .O_WriteReg(wreg),
        .O_Rs(ors), .O_Rt(ort), .O_Stall(stall), .O_Illegal(ill)
    );

    typedef struct {
        logic [15:0] rd1, rd2, imm, pc;
        logic [8:0]  ctl;   // {alusrc, aluop[1:0], regw, memr, memw, m2r, br, ill}
        logic [2:0]  wreg, rs, rt;
    } exp_t;

    localparam logic [8:0] C_BUB  = 9'b0_00_0_0_0_0_0_0;
    localparam logic [8:0] C_R    = 9'b0_10_1_0_0_0_0_0;
    localparam logic [8:0] C_LW   = 9'b1_00_1_1_0_1_0_0;
    localparam logic [8:0] C_ADDI = 9'b1_00_1_0_0_0_0_0;
    localparam logic [8:0] C_BEQ  = 9'b0_01_0_0_0_0_1_0;
    localparam logic [8:0] C_ILL  = 9'b0_00_0_0_0_0_0_1;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] r1, r2, im, p, input logic [8:0] c,
                                input logic [2:0] w, s, t);
        exp_t e;
        e.rd1 = r1; e.rd2 = r2; e.imm = im; e.pc = p; e.ctl = c;
        e.wreg = w; e.rs = s; e.rt = t;
        return e;
    endfunction

    task automatic compare(input string name, input exp_t e);
        chk({name, ".rd1"}, {16'h0, rd1}, {16'h0, e.rd1});
        chk({name, ".rd2"}, {16'h0, rd2}, {16'h0, e.rd2});
        chk({name, ".imm"}, {16'h0, imm}, {16'h0, e.imm});
        chk({name, ".pc"}, {16'h0, pco}, {16'h0, e.pc});
        chk({name, ".ctl"}, {23'h0, alusrc, aluop, regw, memr, memw, m2r, br, ill},
            {23'h0, e.ctl});
        chk({name, ".wreg"}, {29'h0, wreg}, {29'h0, e.wreg});
        chk({name, ".rs"}, {29'h0, ors}, {29'h0, e.rs});
        chk({name, ".rt"}, {29'h0, ort}, {29'h0, e.rt});
    endtask

    task automatic cycle(input string name, input logic [15:0] i, p, input logic v, f,
                         input logic we, input logic [2:0] wa, input logic [15:0] wd,
                         input exp_t e, input logic exp_stall);
        exp_t got_e;
        @(negedge clk);
        instr = i; pc = p; valid = v; flush = f;
        wb_we = we; wb_wa = wa; wb_wd = wd;
        sb.push_back(e);
        #1 chk({name, ".stall"}, {31'h0, stall}, {31'h0, exp_stall});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({name, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            got_e = sb.pop_front();
            compare(name, got_e);
        end
    endtask

    exp_t bub;

    initial begin
        bub = mk(16'h0, 16'h0, 16'h0, 16'h0, C_BUB, 3'd0, 3'd0, 3'd0);
        rst_n = 1'b0; instr = '0; pc = '0; valid = 1'b0; flush = 1'b0;
        wb_we = 1'b0; wb_wa = '0; wb_wd = '0;
        #12;
        compare("reset", bub);
        chk("reset.stall", {31'h0, stall}, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // Register file loads through WB during idle slots; r0 write must be ignored.
        cycle("wb_r3", 16'h0000, 16'h0, 0, 0, 1, 3'd3, 16'h1234, bub, 0);
        cycle("wb_r0", 16'h0000, 16'h0, 0, 0, 1, 3'd0, 16'hFFFF, bub, 0);
        cycle("wb_r1", 16'h0000, 16'h0, 0, 0, 1, 3'd1, 16'h0011, bub, 0);
        cycle("wb_r4", 16'h0000, 16'h0, 0, 0, 1, 3'd4, 16'h0044, bub, 0);

        cycle("radd", 16'h062A, 16'h0010, 1, 0, 0, 3'd0, 16'h0,
              mk(16'h1234, 16'h0000, 16'h0002, 16'h0010, C_R, 3'd5, 3'd3, 3'd0), 0);
        cycle("addi_neg", 16'h767E, 16'h0012, 1, 0, 0, 3'd0, 16'h0,
              mk(16'h1234, 16'h0011, 16'hFFFE, 16'h0012, C_ADDI, 3'd1, 3'd3, 3'd1), 0);
        cycle("bypass", 16'h7401, 16'h0014, 1, 0, 1, 3'd2, 16'hBEEF,
              mk(16'hBEEF, 16'h0000, 16'h0001, 16'h0014, C_ADDI, 3'd0, 3'd2, 3'd0), 0);

        // Load-use: LW r4 then add r6,r4,r1 stalls once, then issues.
        cycle("lw", 16'h4303, 16'h0016, 1, 0, 0, 3'd0, 16'h0,
              mk(16'h0011, 16'h0044, 16'h0003, 16'h0016, C_LW, 3'd4, 3'd1, 3'd4), 0);
        cycle("lu_stall", 16'h0870, 16'h0018, 1, 0, 0, 3'd0, 16'h0, bub, 1);
        cycle("lu_issue", 16'h0870, 16'h0018, 1, 0, 0, 3'd0, 16'h0,
              mk(16'h0044, 16'h0011, 16'h0000, 16'h0018, C_R, 3'd6, 3'd4, 3'd1), 0);

        // ADDI's rt is a destination, so matching it must not stall.
        cycle("lw2", 16'h4303, 16'h001A, 1, 0, 0, 3'd0, 16'h0,
              mk(16'h0011, 16'h0044, 16'h0003, 16'h001A, C_LW, 3'd4, 3'd1, 3'd4), 0);
        cycle("nodep", 16'h7301, 16'h001C, 1, 0, 0, 3'd0, 16'h0,
              mk(16'h0011, 16'h0044, 16'h0001, 16'h001C, C_ADDI, 3'd4, 3'd1, 3'd4), 0);

        cycle("lw3", 16'h4303, 16'h001E, 1, 0, 0, 3'd0, 16'h0,
              mk(16'h0011, 16'h0044, 16'h0003, 16'h001E, C_LW, 3'd4, 3'd1, 3'd4), 0);
        cycle("flush", 16'h0870, 16'h0020, 1, 1, 0, 3'd0, 16'h0, bub, 0);
        cycle("beq", 16'h6302, 16'h0022, 1, 0, 0, 3'd0, 16'h0,
              mk(16'h0011, 16'h0044, 16'h0002, 16'h0022, C_BEQ, 3'd0, 3'd1, 3'd4), 0);
        cycle("illegal", 16'hA000, 16'h0024, 1, 0, 0, 3'd0, 16'h0,
              mk(16'h0000, 16'h0000, 16'h0000, 16'h0024, C_ILL, 3'd0, 3'd0, 3'd0), 0);

        // Asynchronous reset mid-cycle with a write pending.
        @(negedge clk);
        instr = 16'h062A; pc = 16'h0030; valid = 1'b1; flush = 1'b0;
        wb_we = 1'b1; wb_wa = 3'd5; wb_wd = 16'h5555;
        #1 rst_n = 1'b0;
        #1 compare("rst_async", bub);
        chk("rst_async.stall", {31'h0, stall}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; wb_we = 1'b0;

        for (int r = 1; r < 8; r++) begin
            logic [2:0] ra;
            ra = 3'(r);
            cycle($sformatf("rf_clr%0d", r), {4'b0000, ra, ra, 6'b000000}, 16'h0040 + 16'(2*r),
                  1, 0, 0, 3'd0, 16'h0,
                  mk(16'h0000, 16'h0000, 16'h0000, 16'h0040 + 16'(2*r), C_R, 3'd0, ra, ra), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
